program_counter: RTL and testbench
==================================

# program_counter

8-bit program counter for the 4-bit microprocessor datapath. It holds the address of the next instruction, increments it or loads a new value, and drives it onto the shared address/data bus through a tri-state output. The control unit sequences it through `clr`, `pc_inc`, `load_pc` and `pc_oen`.

## Interface

Clocking: one clock `clk`. Reset `clr` is synchronous and active-high.

Parameters
- `WIDTH`, default 8: counter and bus width in bits.

Ports
- `clk`: input, 1 bit. Rising-edge clock.
- `clr`: input, 1 bit. Synchronous active-high reset. Clears the count to 0.
- `pc_inc`: input, 1 bit. Increment enable, active-high.
- `load_pc`: input, 1 bit. Parallel-load enable, active-high.
- `pc_input`: input, WIDTH bits. Value to load.
- `pc_oen`: input, 1 bit. Output enable, active-low. 0 drives the bus; 1 puts it in high-Z.
- `pc_out`: output, WIDTH bits. Tri-state bus output of the count register.

## Operation

- Internal register `count[WIDTH-1:0]` is updated only on the rising edge of `clk`.
- Update priority at each rising edge, first match wins:
  - `clr`=1: count ← 0.
  - `load_pc`=1: count ← `pc_input`.
  - `pc_inc`=1: count ← count + 1, modulo 2^WIDTH. 8'hFF wraps to 8'h00, with no carry output.
  - Otherwise: count holds.
- `load_pc` and `pc_inc` both high: load wins and no increment is applied.
- `clr` overrides everything, including a load or increment in the same cycle.
- Output drive is combinational:
  - `pc_oen`=0: `pc_out` = count.
  - `pc_oen`=1: `pc_out` = all bits Z.
  - `pc_oen` has no effect on count.
- Count value at power-up is undefined until the first rising edge with `clr`=1.
- Reset value: count = 0. `pc_out` = 0 while `pc_oen`=0, otherwise Z.
- No internal state other than count. No handshake.

## Timing

- Load, increment and clear take effect one cycle after sampling. The new count is visible on `pc_out` (if enabled) right after the sampling edge.
- A `pc_inc` held high for N consecutive edges advances the count by exactly N.
- `clr` asserted mid-count: count is 0 after the next edge, regardless of other inputs.
- `pc_oen` toggling: `pc_out` switches between count and Z combinationally, with no clock latency.
- Inputs must be stable around the rising edge. All are sampled only at `clk` rising edges, except `pc_oen`.

## Test plan

1. Reset with output enabled:
   - Stimulus: `clr`=1 for 1 edge, `pc_oen`=0.
   - Required: `pc_out`=8'h00. Hold with all controls 0 keeps 8'h00.
2. Increment run:
   - Stimulus: after reset, `pc_inc`=1 for 5 edges, then 0.
   - Required: `pc_out` steps 01, 02, 03, 04, 05 and then holds 8'h05.
3. Load:
   - Stimulus: `pc_input`=8'h13, `load_pc`=1 for 1 edge.
   - Required: `pc_out`=8'h13, held after `load_pc` drops.
   - Variant: `load_pc` and `pc_inc` both high with `pc_input`=8'h40 gives 8'h40, not 8'h41.
4. Output enable:
   - Stimulus: `pc_oen`=1.
   - Required: `pc_out` is all Z.
   - Then `pc_oen`=0: `pc_out` shows the unchanged count (e.g. 8'h13) immediately.
   - Count is unaffected by toggling `pc_oen` across clock edges.
5. Wrap-around:
   - Stimulus: load 8'hFE, then `pc_inc`=1 for 3 edges.
   - Required: `pc_out` sequence is FF, 00, 01.
6. Clear priority:
   - Stimulus: count = 8'h13; assert `clr`=1 together with `load_pc`=1 (`pc_input`=8'hAA) and `pc_inc`=1 for 1 edge.
   - Required: `pc_out`=8'h00.
   - After `clr` drops with `pc_inc`=1: the count resumes incrementing to 01.

Source files
------------

// File: rtl/program_counter.sv
// Program counter for the 4-bit microprocessor datapath. It holds the next
// instruction address, increments or loads it, and drives a tri-state bus.
module program_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pc_inc,
    input  logic             load_pc,
    input  logic [WIDTH-1:0] pc_input,
    input  logic             pc_oen,
    output logic [WIDTH-1:0] pc_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Priority: clear, then load, then increment; increment wraps silently.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load_pc) begin
            count_d = pc_input;
        end else if (pc_inc) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    // Bus drive follows pc_oen combinationally; it never touches the count.
    assign pc_out = pc_oen ? {WIDTH{1'bz}} : count_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter: reset, increment, load,
// output enable, wrap-around and clear priority.
module tb_program_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       pc_inc = 1'b0;
    logic       load_pc = 1'b0;
    logic [7:0] pc_input = 8'h00;
    logic       pc_oen = 1'b1;
    wire  [7:0] pc_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] zval;

    program_counter #(.WIDTH(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .pc_inc   (pc_inc),
        .load_pc  (load_pc),
        .pc_input (pc_input),
        .pc_oen   (pc_oen),
        .pc_out   (pc_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic i, input logic [7:0] d);
        clr = c;
        load_pc = l;
        pc_inc = i;
        pc_input = d;
    endtask

    task automatic test_reset();
        pc_oen = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        checks++;
        if (pc_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_value: got %h expected %h", pc_out, 8'h00);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checks++;
        if (pc_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", pc_out, 8'h00);
        end
    endtask

    task automatic test_increment();
        logic [7:0] exp;
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = 8'(k);
            checks++;
            if (pc_out !== exp) begin
                errors++;
                $display("FAIL inc_step%0d: got %h expected %h", k, pc_out, exp);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checks++;
        if (pc_out !== 8'h05) begin
            errors++;
            $display("FAIL inc_hold: got %h expected %h", pc_out, 8'h05);
        end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, 1'b0, 8'h40);
        pc_inc = 1'b1;
        tick();
        checks++;
        if (pc_out !== 8'h40) begin
            errors++;
            $display("FAIL load_beats_inc: got %h expected %h", pc_out, 8'h40);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h13);
        tick();
        checks++;
        if (pc_out !== 8'h13) begin
            errors++;
            $display("FAIL load_value: got %h expected %h", pc_out, 8'h13);
        end
        drive(1'b0, 1'b0, 1'b0, 8'hEE);
        tick();
        tick();
        checks++;
        if (pc_out !== 8'h13) begin
            errors++;
            $display("FAIL load_hold: got %h expected %h", pc_out, 8'h13);
        end
    endtask

    task automatic test_output_enable();
        zval = 8'bzzzz_zzzz;
        pc_oen = 1'b1;
        #1;
        checks++;
        if (pc_out !== zval) begin
            errors++;
            $display("FAIL oen_highz: got %b expected %b", pc_out, zval);
        end
        pc_oen = 1'b0;
        #1;
        checks++;
        if (pc_out !== 8'h13) begin
            errors++;
            $display("FAIL oen_restore: got %h expected %h", pc_out, 8'h13);
        end
        pc_oen = 1'b1;
        tick();
        tick();
        checks++;
        if (pc_out !== zval) begin
            errors++;
            $display("FAIL oen_highz_edges: got %b expected %b", pc_out, zval);
        end
        pc_oen = 1'b0;
        #1;
        checks++;
        if (pc_out !== 8'h13) begin
            errors++;
            $display("FAIL oen_count_kept: got %h expected %h", pc_out, 8'h13);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [3];
        seq[0] = 8'hFF;
        seq[1] = 8'h00;
        seq[2] = 8'h01;
        drive(1'b0, 1'b1, 1'b0, 8'hFE);
        tick();
        checks++;
        if (pc_out !== 8'hFE) begin
            errors++;
            $display("FAIL wrap_load: got %h expected %h", pc_out, 8'hFE);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pc_out !== seq[k]) begin
                errors++;
                $display("FAIL wrap_step%0d: got %h expected %h", k, pc_out, seq[k]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_clear_priority();
        drive(1'b0, 1'b1, 1'b0, 8'h13);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'hAA);
        tick();
        checks++;
        if (pc_out !== 8'h00) begin
            errors++;
            $display("FAIL clr_priority: got %h expected %h", pc_out, 8'h00);
        end
        drive(1'b0, 1'b0, 1'b1, 8'hAA);
        tick();
        checks++;
        if (pc_out !== 8'h01) begin
            errors++;
            $display("FAIL clr_resume: got %h expected %h", pc_out, 8'h01);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b0, 8'h7F);
        tick();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        checks++;
        if (pc_out !== 8'h80) begin
            errors++;
            $display("FAIL b2b_inc: got %h expected %h", pc_out, 8'h80);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        tick();
        checks++;
        if (pc_out !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_load: got %h expected %h", pc_out, 8'h5A);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #2;
        test_reset();
        test_increment();
        test_load();
        test_output_enable();
        test_wrap();
        test_clear_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
